pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter register plus instruction-fetch sequencer for the single-cycle CPU.
- Holds the PC and fetches one word from instruction memory over a req/ack handshake, then presents it to decode.
- Selects the next PC from the sequential, branch, jump and jump-register sources.
- Sits directly upstream of the jump-target stage: pc_plus4_o[31:28] feeds that stage's upper-PC input, and the finished jump target returns on jump_target_i.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ACK_TIMEOUT, 16, fetch-wait cycles before fetch_err_o is flagged.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- stall_i  in  1  decode/execute not ready; hold the current instruction.
- branch_i  in  1  take branch_target_i.
- branch_target_i  in  32  PC+4+(sext(imm)<<2).
- jump_i  in  1  take jump_target_i.
- jump_target_i  in  32  {pc_plus4[31:28], addr26, 2'b00}.
- jr_i  in  1  take jr_target_i.
- jr_target_i  in  32  register-sourced target.
- imem_ack_i  in  1  read data valid.
- imem_rdata_i  in  32  instruction word.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address (equals pc_o).
- pc_o  out  32  current PC.
- pc_plus4_o  out  32  pc_o + 4.
- instr_o  out  32  registered instruction.
- instr_valid_o  out  1  instr_o valid for the current PC.
- fetch_err_o  out  1  sticky ack timeout.
- misalign_o  out  1  sticky: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (rst_i=0, asynchronous) drives:
  - pc_o=RESET_PC, pc_plus4_o=RESET_PC+4.
  - instr_o=0, instr_valid_o=0, imem_req_o=0.
  - fetch_err_o=0, misalign_o=0, timeout counter=0, state=S_IDLE.
- States:
  - S_IDLE: one cycle after reset release, then go to S_FETCH.
  - S_FETCH:
    - imem_req_o=1, imem_addr_o=pc_o; increment the timeout counter each cycle.
    - On imem_ack_i=1: instr_o<=imem_rdata_i, instr_valid_o<=1, counter<=0, go to S_EXEC.
    - The earliest legal ack is in the cycle after req rises. Ack in S_IDLE/S_EXEC is ignored.
  - S_EXEC:
    - imem_req_o=0, instr_valid_o=1.
    - If stall_i=1: hold everything and stay in S_EXEC.
    - If stall_i=0: pc_o<=next_pc, instr_valid_o<=0, go to S_FETCH.
  - Fetch latency is 1 + memory latency. Minimum instruction throughput is one instruction per 2 cycles with zero-wait memory.
- Next-PC priority (sampled only in S_EXEC with stall_i=0), highest first:
  - jr_i -> jr_target_i.
  - jump_i -> jump_target_i.
  - branch_i -> branch_target_i.
  - otherwise pc_plus4_o.
- Redirect inputs are don't-care outside that cycle.
- Alignment: the selected target has bits [1:0] forced to 00. If the raw bits were non-zero, misalign_o<=1 (sticky until reset).
- pc_plus4_o is combinational pc_o+4. Arithmetic wraps mod 2^32, so 32'hFFFF_FFFC -> 32'h0000_0000.
- Timeout: the counter reaching ACK_TIMEOUT in S_FETCH sets fetch_err_o=1 (sticky). The request stays asserted and the counter saturates. A later ack completes normally.
- Reset mid-fetch: imem_req_o drops immediately (asynchronous) and any in-flight ack is ignored. After reset release the first request is at RESET_PC.
- Simultaneous stall_i=1 and redirect: the redirect is ignored this cycle and re-evaluated on the first non-stalled S_EXEC cycle.

Decomposition:
- Shared cpu_pkg holds:
  - State enum {S_IDLE, S_FETCH, S_EXEC}.
  - Next-PC select encoding {NPC_SEQ, NPC_BR, NPC_J, NPC_JR}.
  - RESET_PC default.
- One natural sub-module: next_pc_mux (combinational priority select plus alignment check), reusable by a later pipelined fetch.

Test Plan:
1. Reset with RESET_PC=0, zero-wait memory returning 32'h2008_0005 -> imem_req_o rises 1 cycle after release with addr 0; instr_valid_o=1 with instr_o=32'h2008_0005; next request at addr 4.
2. Sequential run of 3 instructions with ack delay 3 -> requests at 0, 4, 8; each instr_valid_o pulse exactly 1 cycle (no stall); pc_plus4_o = 4, 8, 12.
3. In S_EXEC at pc 0x0040_0010, assert jump_i with jump_target_i=0x0040_0100 and branch_i together -> next request addr 0x0040_0100 (jump wins); with jr_i also high and jr_target_i=0x0000_0080 -> addr 0x0000_0080.
4. stall_i high for 4 cycles in S_EXEC with jump_i pulsed during the stall, then low with no redirect -> instr_o held for 5 cycles; next PC = pc+4 (the pulsed jump is lost).
5. No ack for 20 cycles (ACK_TIMEOUT=16) -> fetch_err_o=1 from the 16th wait cycle onward, imem_req_o stays 1; a late ack is accepted and fetch_err_o stays 1.
6. jr_target_i=0x0000_0103 -> fetch addr 0x0000_0100 and misalign_o=1. Pulse rst_i low mid-fetch -> imem_req_o=0 immediately, all flags clear, the refetch is at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage types, select encodings and reset defaults
package cpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC
    } fetch_state_t;

    typedef enum logic [1:0] {
        NPC_SEQ,
        NPC_BR,
        NPC_J,
        NPC_JR
    } npc_sel_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_mux.sv
// rtl/next_pc_mux.sv - priority next-PC select with word alignment and misalign detect
module next_pc_mux
    import cpu_pkg::*;
(
    input  logic [31:0] pc_plus4_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] next_pc_o,
    output logic        misaligned_o
);

    npc_sel_t    sel;
    logic [31:0] raw_target;

    always_comb begin
        sel = NPC_SEQ;
        if (jr_i) begin
            sel = NPC_JR;
        end else if (jump_i) begin
            sel = NPC_J;
        end else if (branch_i) begin
            sel = NPC_BR;
        end
    end

    always_comb begin
        raw_target = pc_plus4_i;
        case (sel)
            NPC_SEQ: raw_target = pc_plus4_i;
            NPC_BR:  raw_target = branch_target_i;
            NPC_J:   raw_target = jump_target_i;
            NPC_JR:  raw_target = jr_target_i;
            default: raw_target = pc_plus4_i;
        endcase
    end

    // The sequential path is aligned by construction; only redirects can flag.
    assign next_pc_o    = word_align(raw_target);
    assign misaligned_o = (sel != NPC_SEQ) && (raw_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and req/ack instruction fetch sequencer
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        fetch_err_o,
    output logic        misalign_o
);

    localparam int               CNT_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [31:0]      pc_q;
    logic [31:0]      instr_q;
    logic             instr_valid_q;
    logic             fetch_err_q;
    logic             misalign_q;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      next_pc;
    logic             target_misaligned;
    logic             take_ack;
    logic             advance;
    logic             fetch_req;

    assign pc_plus4_o    = pc_q + 32'd4;
    assign pc_o          = pc_q;
    assign imem_addr_o   = pc_q;
    assign imem_req_o    = fetch_req;
    assign instr_o       = instr_q;
    assign instr_valid_o = instr_valid_q;
    assign fetch_err_o   = fetch_err_q;
    assign misalign_o    = misalign_q;

    next_pc_mux u_next_pc_mux (
        .pc_plus4_i      (pc_plus4_o),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .jr_i            (jr_i),
        .jr_target_i     (jr_target_i),
        .next_pc_o       (next_pc),
        .misaligned_o    (target_misaligned)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request is decoded from the state register so reset drops it at once.
    always_comb begin
        state_next = state;
        fetch_req  = 1'b0;
        take_ack   = 1'b0;
        advance    = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                fetch_req = 1'b1;
                if (imem_ack_i) begin
                    take_ack   = 1'b1;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!stall_i) begin
                    advance    = 1'b1;
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            misalign_q    <= 1'b0;
            wait_cnt      <= '0;
        end else begin
            if (take_ack) begin
                instr_q       <= imem_rdata_i;
                instr_valid_q <= 1'b1;
                wait_cnt      <= '0;
            end else if (state == S_FETCH) begin
                if (wait_cnt != CNT_MAX) begin
                    wait_cnt <= wait_cnt + CNT_ONE;
                end
                if (wait_cnt >= CNT_MAX - CNT_ONE) begin
                    fetch_err_q <= 1'b1;
                end
            end
            if (advance) begin
                pc_q          <= next_pc;
                instr_valid_q <= 1'b0;
                if (target_misaligned) begin
                    misalign_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed and randomized self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_target_i = 32'd0;
    logic        jump_i = 1'b0;
    logic [31:0] jump_target_i = 32'd0;
    logic        jr_i = 1'b0;
    logic [31:0] jr_target_i = 32'd0;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'd0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        fetch_err_o;
    logic        misalign_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_mis;
    logic        exp_err;

    pc_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .jr_i            (jr_i),
        .jr_target_i     (jr_target_i),
        .imem_ack_i      (imem_ack_i),
        .imem_rdata_i    (imem_rdata_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .pc_o            (pc_o),
        .pc_plus4_o      (pc_plus4_o),
        .instr_o         (instr_o),
        .instr_valid_o   (instr_valid_o),
        .fetch_err_o     (fetch_err_o),
        .misalign_o      (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    function automatic logic [31:0] ref_pick(input logic [31:0] pc,
                                             input logic br, input logic [31:0] bt,
                                             input logic j, input logic [31:0] jt,
                                             input logic jr, input logic [31:0] jrt);
        if (jr) return jrt;
        if (j) return jt;
        if (br) return bt;
        return pc + 32'd4;
    endfunction

    task automatic clear_redirect();
        branch_i = 1'b0; jump_i = 1'b0; jr_i = 1'b0;
        branch_target_i = $urandom; jump_target_i = $urandom; jr_target_i = $urandom;
    endtask

    // Called at a negedge while the DUT is in, or about to enter, the fetch state.
    task automatic fetch(input int lat, input logic [31:0] data);
        int n;
        n = 0;
        while (!imem_req_o && n < 8) begin
            tick();
            n++;
        end
        chk("req_seen", imem_req_o, 1);
        chk("fetch_addr", imem_addr_o, exp_pc);
        chk("pc_plus4", pc_plus4_o, exp_pc + 32'd4);
        chk("valid_low_in_fetch", instr_valid_o, 0);
        for (int i = 0; i < lat; i++) begin
            imem_ack_i = 1'b0;
            tick();
            chk("req_held_wait", imem_req_o, 1);
        end
        imem_ack_i = 1'b1;
        imem_rdata_i = data;
        tick();
        imem_ack_i = 1'b0;
        imem_rdata_i = $urandom;
        exp_instr = data;
        chk("instr_valid", instr_valid_o, 1);
        chk("instr", instr_o, exp_instr);
        chk("req_drop_exec", imem_req_o, 0);
        chk("fetch_err", fetch_err_o, exp_err);
    endtask

    // Called at a negedge in the execute state; garbage redirects during stalls must be ignored.
    task automatic exec(input int stalls,
                        input logic br, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt,
                        input logic jr, input logic [31:0] jrt);
        logic [31:0] pick;
        for (int i = 0; i < stalls; i++) begin
            stall_i = 1'b1;
            branch_i = $urandom_range(0, 1);
            jump_i = $urandom_range(0, 1);
            jr_i = $urandom_range(0, 1);
            branch_target_i = $urandom; jump_target_i = $urandom; jr_target_i = $urandom;
            tick();
            chk("stall_valid", instr_valid_o, 1);
            chk("stall_instr", instr_o, exp_instr);
            chk("stall_pc", pc_o, exp_pc);
            chk("stall_req", imem_req_o, 0);
            chk("stall_mis", misalign_o, exp_mis);
        end
        stall_i = 1'b0;
        branch_i = br; branch_target_i = bt;
        jump_i = j; jump_target_i = jt;
        jr_i = jr; jr_target_i = jrt;
        pick = ref_pick(exp_pc, br, bt, j, jt, jr, jrt);
        tick();
        clear_redirect();
        exp_pc = pick - (pick % 32'd4);
        if ((pick % 32'd4) != 32'd0) exp_mis = 1'b1;
        chk("next_valid_low", instr_valid_o, 0);
        chk("next_req", imem_req_o, 1);
        chk("next_addr", imem_addr_o, exp_pc);
        chk("misalign", misalign_o, exp_mis);
    endtask

    initial begin
        logic        rb, rj, rjr;
        logic [31:0] rbt, rjt, rjrt;

        exp_pc = 32'h0; exp_instr = 32'h0; exp_mis = 1'b0; exp_err = 1'b0;

        // Reset state and first fetch from zero-wait memory
        repeat (3) @(negedge clk_i);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_pc_plus4", pc_plus4_o, 32'h4);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_valid", instr_valid_o, 0);
        chk("rst_req", imem_req_o, 0);
        chk("rst_err", fetch_err_o, 0);
        chk("rst_mis", misalign_o, 0);
        rst_i = 1'b1;
        chk("idle_req", imem_req_o, 0);
        tick();
        chk("first_req", imem_req_o, 1);
        fetch(0, 32'h2008_0005);
        exec(0, 0, 0, 0, 0, 0, 0);
        chk("second_addr", imem_addr_o, 32'h4);

        // Sequential run with ack delay 3
        fetch(3, 32'h1111_0004);
        exec(0, 0, 0, 0, 0, 0, 0);
        fetch(3, 32'h1111_0008);
        exec(0, 0, 0, 0, 0, 0, 0);
        chk("seq_pc_plus4", pc_plus4_o, 32'd16);

        // Redirect priority
        fetch(1, 32'h2222_000c);
        exec(0, 0, 0, 1, 32'h0040_0010, 0, 0);
        fetch(0, 32'h3333_0010);
        exec(0, 1, 32'h0000_2000, 1, 32'h0040_0100, 0, 0);
        chk("jump_wins", imem_addr_o, 32'h0040_0100);
        fetch(2, 32'h3333_0100);
        exec(0, 1, 32'h0000_2000, 1, 32'h0040_0200, 1, 32'h0000_0080);
        chk("jr_wins", imem_addr_o, 32'h0000_0080);

        // Stall with jump pulsed in the middle; jump is lost
        fetch(0, 32'h4444_0080);
        exec(4, 0, 0, 0, 0, 0, 0);
        chk("stall_seq", imem_addr_o, 32'h0000_0084);

        // Ack timeout
        chk("pre_timeout_addr", imem_addr_o, exp_pc);
        for (int i = 1; i <= 20; i++) begin
            imem_ack_i = 1'b0;
            tick();
            if (i == 15) chk("err_before_16", fetch_err_o, 0);
            if (i == 16) chk("err_at_16", fetch_err_o, 1);
        end
        chk("timeout_req_held", imem_req_o, 1);
        exp_err = 1'b1;
        fetch(0, 32'h5555_0084);

        // Misaligned jr target, then reset mid-fetch
        exec(0, 0, 0, 0, 0, 1, 32'h0000_0103);
        chk("mis_addr", imem_addr_o, 32'h0000_0100);
        chk("mis_flag", misalign_o, 1);
        tick();
        imem_ack_i = 1'b1;
        imem_rdata_i = 32'hdead_beef;
        rst_i = 1'b0;
        #1;
        chk("rst_mid_req", imem_req_o, 0);
        chk("rst_mid_pc", pc_o, 32'h0);
        chk("rst_mid_err", fetch_err_o, 0);
        chk("rst_mid_mis", misalign_o, 0);
        chk("rst_mid_valid", instr_valid_o, 0);
        tick();
        imem_ack_i = 1'b0;
        rst_i = 1'b1;
        exp_pc = 32'h0; exp_mis = 1'b0; exp_err = 1'b0;
        tick();
        chk("refetch_addr", imem_addr_o, 32'h0);
        fetch(1, 32'h6666_0000);

        // Wrap at the top of the address space
        exec(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4_o, 32'h0);
        fetch(0, 32'h7777_fffc);
        exec(0, 0, 0, 0, 0, 0, 0);
        chk("wrap_addr", imem_addr_o, 32'h0);

        // Randomized traffic against the reference model
        for (int it = 0; it < 40; it++) begin
            fetch($urandom_range(0, 4), $urandom);
            rb = ($urandom_range(0, 2) == 0);
            rj = ($urandom_range(0, 3) == 0);
            rjr = ($urandom_range(0, 4) == 0);
            rbt = $urandom & 32'hFFFF_FFFC;
            rjt = $urandom & 32'hFFFF_FFFC;
            rjrt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) rjrt = rjrt | 32'h1;
            if ($urandom_range(0, 7) == 0) rbt = rbt | 32'h2;
            exec($urandom_range(0, 2), rb, rbt, rj, rjt, rjr, rjrt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
